// File: rtl/adsr_pkg.sv
// ---------------------------------------------------------------------------
// adsr_pkg
// Shared definitions for the ADSR envelope generator:
//   STATE_W     width of the envelope state encoding
//   envState_t  envelope stage encodings (IDLE..RELEASE)
//   lmaxOf()    full-scale level for a given level width (2^w - 1)
// ---------------------------------------------------------------------------
package adsr_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ENV_IDLE    = 3'd0,
        ENV_ATTACK  = 3'd1,
        ENV_DECAY   = 3'd2,
        ENV_SUSTAIN = 3'd3,
        ENV_RELEASE = 3'd4
    } envState_t;

    // Full-scale envelope level for a level register of the given width.
    function automatic logic [63:0] lmaxOf(input int width);
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/adsr_env_if.sv
// ---------------------------------------------------------------------------
// adsr_env_if
// Bundles the voice-path signals of the envelope generator.
//   gate, in_ready, sample_in        note gate, codec strobe, input sample
//   attack/decay/release_step        per-strobe ramp increments
//   sustain_level                    live sustain target
//   sample_out, out_valid            modulated sample and its one-cycle strobe
//   env_level, env_state, busy       envelope status
// master: the side that drives gate/samples/settings (voice controller)
// slave : the envelope generator itself
// ---------------------------------------------------------------------------
interface adsr_env_if #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int LEVEL_WIDTH  = 16
);
    import adsr_pkg::*;

    logic                           gate;
    logic                           in_ready;
    logic signed [SAMPLE_WIDTH-1:0] sample_in;
    logic        [LEVEL_WIDTH-1:0]  attack_step;
    logic        [LEVEL_WIDTH-1:0]  decay_step;
    logic        [LEVEL_WIDTH-1:0]  sustain_level;
    logic        [LEVEL_WIDTH-1:0]  release_step;
    logic signed [SAMPLE_WIDTH-1:0] sample_out;
    logic                           out_valid;
    logic        [LEVEL_WIDTH-1:0]  env_level;
    logic        [STATE_W-1:0]      env_state;
    logic                           busy;

    modport master (
        output gate, in_ready, sample_in,
        output attack_step, decay_step, sustain_level, release_step,
        input  sample_out, out_valid, env_level, env_state, busy
    );

    modport slave (
        input  gate, in_ready, sample_in,
        input  attack_step, decay_step, sustain_level, release_step,
        output sample_out, out_valid, env_level, env_state, busy
    );

endinterface

// File: rtl/adsr_gain.sv
// ---------------------------------------------------------------------------
// adsr_gain
// Scales a signed sample by an unsigned envelope level (gain = level/2^LW,
// never above 1) and registers the result with a one-cycle valid pulse.
//   clk, reset   clock, asynchronous active-low reset
//   i_strobe     sample strobe; the product is captured on this cycle
//   i_sample     signed input sample
//   i_level      envelope level in effect before this strobe's update
//   o_sample     registered scaled sample (holds between strobes)
//   o_valid      high for the cycle after each strobe
// ---------------------------------------------------------------------------
module adsr_gain #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int LEVEL_WIDTH  = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           i_strobe,
    input  logic signed [SAMPLE_WIDTH-1:0] i_sample,
    input  logic        [LEVEL_WIDTH-1:0]  i_level,
    output logic signed [SAMPLE_WIDTH-1:0] o_sample,
    output logic                           o_valid
);

    // The magnitude of sample*level stays below 2^(SW+LW-1), so SW+LW
    // signed bits hold the product exactly.
    localparam int PW = SAMPLE_WIDTH + LEVEL_WIDTH;

    logic signed [PW-1:0]           w_sampleExt;
    logic signed [PW-1:0]           w_levelExt;
    logic signed [PW-1:0]           w_prod;
    logic signed [SAMPLE_WIDTH-1:0] w_scaled;
    logic                           w_unusedLow;

    assign w_sampleExt = PW'(i_sample);
    assign w_levelExt  = PW'({1'b0, i_level});
    assign w_prod      = w_sampleExt * w_levelExt;

    // Taking the upper bits of a two's-complement product is an arithmetic
    // shift right by LEVEL_WIDTH, i.e. truncation toward minus infinity.
    assign w_scaled    = w_prod[LEVEL_WIDTH +: SAMPLE_WIDTH];
    assign w_unusedLow = ^w_prod[LEVEL_WIDTH-1:0];

    // Output register: new sample on strobe, hold otherwise; valid mirrors
    // the strobe one cycle late.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_sample <= '0;
            o_valid  <= 1'b0;
        end else begin
            o_valid <= i_strobe;
            if (i_strobe) begin
                o_sample <= w_scaled;
            end
        end
    end

endmodule

// File: rtl/adsr_env.sv
// ---------------------------------------------------------------------------
// adsr_env
// Gate-driven ADSR envelope generator with linear, runtime-programmable
// ramps, live sustain level and retrigger, followed by an amplitude stage.
// Everything advances only on codec sample strobes (bus.in_ready).
//   clk, reset   clock, asynchronous active-low reset
//   bus          adsr_env_if slave: gate/sample/step inputs, modulated
//                sample + valid, envelope level/state/busy outputs
// ---------------------------------------------------------------------------
module adsr_env
    import adsr_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 16,
    parameter int LEVEL_WIDTH  = 16
) (
    input  logic     clk,
    input  logic     reset,
    adsr_env_if.slave bus
);

    localparam logic [63:0]          LMAX64 = lmaxOf(LEVEL_WIDTH);
    localparam logic [LEVEL_WIDTH:0] LMAX_W = LMAX64[LEVEL_WIDTH:0];

    envState_t              r_state;
    logic [LEVEL_WIDTH-1:0] r_level;
    logic                   r_gateQ;

    envState_t              w_stateNext;
    logic [LEVEL_WIDTH-1:0] w_levelNext;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_inNote;
    logic [LEVEL_WIDTH:0]   w_attackSum;
    logic [LEVEL_WIDTH:0]   w_decayFloor;

    assign w_rise   = bus.gate & ~r_gateQ;
    assign w_fall   = ~bus.gate & r_gateQ;
    assign w_inNote = (r_state == ENV_ATTACK) || (r_state == ENV_DECAY) ||
                      (r_state == ENV_SUSTAIN);

    // One bit of headroom so neither sum can wrap. The decay test
    // level - step <= sustain is rewritten as level <= sustain + step to
    // avoid an underflowing subtraction.
    assign w_attackSum  = {1'b0, r_level} + {1'b0, bus.attack_step};
    assign w_decayFloor = {1'b0, bus.sustain_level} + {1'b0, bus.decay_step};

    // State, level and gate history only move on sample strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ENV_IDLE;
            r_level <= '0;
            r_gateQ <= 1'b0;
        end else if (bus.in_ready) begin
            r_state <= w_stateNext;
            r_level <= w_levelNext;
            r_gateQ <= bus.gate;
        end
    end

    // Next stage and level. A gate rise retriggers ATTACK from wherever the
    // level currently is (no click); a fall during the note jumps to RELEASE
    // with the level kept; otherwise the current stage ramps.
    always_comb begin
        w_stateNext = r_state;
        w_levelNext = r_level;
        if (w_rise) begin
            w_stateNext = ENV_ATTACK;
        end else if (w_fall && w_inNote) begin
            w_stateNext = ENV_RELEASE;
        end else begin
            case (r_state)
                ENV_IDLE: begin
                    w_levelNext = '0;
                end
                ENV_ATTACK: begin
                    if ((w_attackSum >= LMAX_W) || (bus.attack_step == '0)) begin
                        w_levelNext = LMAX_W[LEVEL_WIDTH-1:0];
                        w_stateNext = ENV_DECAY;
                    end else begin
                        w_levelNext = w_attackSum[LEVEL_WIDTH-1:0];
                    end
                end
                ENV_DECAY: begin
                    if (({1'b0, r_level} <= w_decayFloor) || (bus.decay_step == '0)) begin
                        w_levelNext = bus.sustain_level;
                        w_stateNext = ENV_SUSTAIN;
                    end else begin
                        w_levelNext = r_level - bus.decay_step;
                    end
                end
                ENV_SUSTAIN: begin
                    w_levelNext = bus.sustain_level;
                end
                ENV_RELEASE: begin
                    if ((r_level <= bus.release_step) || (bus.release_step == '0)) begin
                        w_levelNext = '0;
                        w_stateNext = ENV_IDLE;
                    end else begin
                        w_levelNext = r_level - bus.release_step;
                    end
                end
                default: begin
                    w_levelNext = '0;
                    w_stateNext = ENV_IDLE;
                end
            endcase
        end
    end

    // Status outputs come straight from the registered state and level.
    always_comb begin
        bus.env_state = r_state;
        bus.env_level = r_level;
        bus.busy      = (r_state != ENV_IDLE);
    end

    // The gain stage sees the level before this strobe's update.
    adsr_gain #(
        .SAMPLE_WIDTH(SAMPLE_WIDTH),
        .LEVEL_WIDTH (LEVEL_WIDTH)
    ) u_gain (
        .clk     (clk),
        .reset   (reset),
        .i_strobe(bus.in_ready),
        .i_sample(bus.sample_in),
        .i_level (r_level),
        .o_sample(bus.sample_out),
        .o_valid (bus.out_valid)
    );

endmodule

// File: tb/tb_adsr_env.sv
// ---------------------------------------------------------------------------
// tb_adsr_env
// Directed bench for adsr_env: reset, full ADSR cycle, release, retrigger,
// zero-step boundaries, gain sign/latency, back-to-back strobes and
// asynchronous reset mid-note. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_adsr_env;

    logic clk;
    logic reset;
    int   nChecks;
    int   nFails;

    adsr_env_if #(.SAMPLE_WIDTH(16), .LEVEL_WIDTH(16)) bus ();

    adsr_env #(.SAMPLE_WIDTH(16), .LEVEL_WIDTH(16)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Attack/decay cycle with attack 16384, decay 8192, sustain 32768,
    // sample_in 16384: level after each strobe, stage, and the output
    // computed from the previous level (16384*prev >> 16 = prev/4, floored).
    int expLevelA [9] = '{0, 16384, 32768, 49152, 65535, 57343, 49151, 40959, 32768};
    int expStateA [9] = '{1, 1, 1, 1, 2, 2, 2, 2, 3};
    int expOutA   [9] = '{0, 0, 4096, 8192, 12288, 16383, 14335, 12287, 10239};

    // Release from 32768 with release_step 10000.
    int expLevelR [5] = '{32768, 22768, 12768, 2768, 0};
    int expStateR [5] = '{4, 4, 4, 4, 0};

    // 100 MHz free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                               input logic signed [63:0] expected);
        nChecks++;
        assert (observed === expected) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // One strobe: drive at a falling edge, DUT updates on the rising edge,
    // return at the next falling edge with outputs settled.
    task automatic applyStimulus(input logic g, input int x);
        @(negedge clk);
        bus.gate      = g;
        bus.sample_in = 16'(x);
        bus.in_ready  = 1'b1;
        @(negedge clk);
        bus.in_ready  = 1'b0;
    endtask

    task automatic checkEnv(input string tag, input int st, input int lvl);
        checkOutput($sformatf("%s_state", tag), bus.env_state, st);
        checkOutput($sformatf("%s_level", tag), bus.env_level, lvl);
    endtask

    initial begin
        nChecks = 0;
        nFails  = 0;
        reset   = 1'b0;
        bus.gate          = 1'b0;
        bus.in_ready      = 1'b0;
        bus.sample_in     = '0;
        bus.attack_step   = '0;
        bus.decay_step    = '0;
        bus.sustain_level = '0;
        bus.release_step  = '0;

        #12;
        checkEnv("rst", 0, 0);
        checkOutput("rst_sample_out", bus.sample_out, 0);
        checkOutput("rst_out_valid", bus.out_valid, 0);
        checkOutput("rst_busy", bus.busy, 0);
        @(negedge clk);
        reset = 1'b1;

        // Idle strobes: silence, one valid pulse per strobe.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1234 + i);
            checkEnv($sformatf("idle%0d", i), 0, 0);
            checkOutput($sformatf("idle%0d_sample_out", i), bus.sample_out, 0);
            checkOutput($sformatf("idle%0d_valid", i), bus.out_valid, 1);
            @(negedge clk);
            checkOutput($sformatf("idle%0d_valid_low", i), bus.out_valid, 0);
        end

        // Full attack/decay into sustain.
        bus.attack_step   = 16'd16384;
        bus.decay_step    = 16'd8192;
        bus.sustain_level = 16'd32768;
        bus.release_step  = 16'd10000;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 16384);
            checkEnv($sformatf("ad%0d", i), expStateA[i], expLevelA[i]);
            checkOutput($sformatf("ad%0d_sample_out", i), bus.sample_out, expOutA[i]);
        end
        applyStimulus(1'b1, 16384);
        checkEnv("sus_hold", 3, 32768);
        checkOutput("sus_hold_sample_out", bus.sample_out, 8192);

        // Release to idle.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 16384);
            checkEnv($sformatf("rel%0d", i), expStateR[i], expLevelR[i]);
        end
        checkOutput("rel_busy_low", bus.busy, 0);

        // Second note, then retrigger during release at 12768.
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, 0);
        checkEnv("note2_sus", 3, 32768);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 0);
        checkEnv("note2_rel", 4, 12768);
        applyStimulus(1'b1, 0);
        checkEnv("retrig", 1, 12768);
        applyStimulus(1'b1, 0);
        checkEnv("retrig_ramp", 1, 29152);

        // Zero steps jump straight to the stage targets.
        bus.attack_step = 16'd0;
        bus.decay_step  = 16'd0;
        applyStimulus(1'b1, 0);
        checkEnv("zero_attack", 2, 65535);
        applyStimulus(1'b1, 0);
        checkEnv("zero_decay", 3, 32768);
        bus.sustain_level = 16'd1000;
        applyStimulus(1'b1, 0);
        checkEnv("live_sustain", 3, 1000);
        bus.release_step = 16'd0;
        applyStimulus(1'b0, 0);
        checkEnv("zero_rel_enter", 4, 1000);
        applyStimulus(1'b0, 0);
        checkEnv("zero_release", 0, 0);

        // Sign and latency: level 32768 times -3 floors to -2.
        bus.attack_step   = 16'd32768;
        bus.decay_step    = 16'd8192;
        bus.sustain_level = 16'd32768;
        bus.release_step  = 16'd10000;
        applyStimulus(1'b1, 0);
        applyStimulus(1'b1, 0);
        checkEnv("sign_pre", 1, 32768);
        @(negedge clk);
        bus.sample_in = -16'sd3;
        bus.in_ready  = 1'b1;
        #1;
        checkOutput("sign_valid_before_edge", bus.out_valid, 0);
        @(negedge clk);
        bus.in_ready = 1'b0;
        checkOutput("sign_valid", bus.out_valid, 1);
        checkOutput("sign_sample_out", bus.sample_out, -2);
        checkEnv("sign_post", 2, 65535);

        // Back-to-back strobes on consecutive cycles.
        @(negedge clk);
        bus.sample_in = 16'sd100;
        bus.in_ready  = 1'b1;
        @(negedge clk);
        checkOutput("b2b0_valid", bus.out_valid, 1);
        checkOutput("b2b0_sample_out", bus.sample_out, 99);
        checkEnv("b2b0", 2, 57343);
        bus.sample_in = 16'sd200;
        @(negedge clk);
        bus.in_ready = 1'b0;
        checkOutput("b2b1_valid", bus.out_valid, 1);
        checkOutput("b2b1_sample_out", bus.sample_out, 174);
        checkEnv("b2b1", 2, 49151);
        @(negedge clk);
        checkOutput("b2b_valid_low", bus.out_valid, 0);
        checkOutput("b2b_hold", bus.sample_out, 174);

        // Asynchronous reset in the middle of an attack.
        applyStimulus(1'b0, 0);
        checkEnv("pre_rst_rel", 4, 49151);
        applyStimulus(1'b1, 0);
        checkEnv("pre_rst_att", 1, 49151);
        #2;
        reset = 1'b0;
        #1;
        checkEnv("mid_rst", 0, 0);
        checkOutput("mid_rst_sample_out", bus.sample_out, 0);
        checkOutput("mid_rst_busy", bus.busy, 0);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1'b1, 500);
        checkEnv("post_rst_rise", 1, 0);
        checkOutput("post_rst_busy", bus.busy, 1);
        checkOutput("post_rst_sample_out", bus.sample_out, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
